// File: rtl/ros_poll_sequencer.sv
// AXI4-Lite master that runs one ring-oscillator measurement: enable, wait, disable, read three counts.
// One transaction in flight at a time; all outputs registered; results published atomically on done.
module ros_poll_sequencer #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
   parameter int                            WAIT_W             = 16
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic                              start,
   input  logic [WAIT_W-1:0]                 period,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic [95:0]                       result,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   typedef enum logic [3:0] {
      IDLE, WR_START, WR_START_RESP, WAIT, WR_STOP, WR_STOP_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   state_t                            state_q, state_d;
   logic [WAIT_W-1:0]                 cnt_q, cnt_d;
   logic [1:0]                        k_q, k_d;
   logic                              awvalid_q, awvalid_d;
   logic                              wvalid_q, wvalid_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                              bready_q, bready_d;
   logic                              arvalid_q, arvalid_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr_q, araddr_d;
   logic                              rready_q, rready_d;
   logic [63:0]                       shadow_q, shadow_d;
   logic [95:0]                       result_q, result_d;
   logic                              done_q, done_d;
   logic                              error_q, error_d;
   logic                              busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      rready_d  = rready_q;
      shadow_d  = shadow_q;
      result_d  = result_q;
      done_d    = 1'b0;
      error_d   = error_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = WR_START;
               error_d   = 1'b0;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = BASE_ADDR;
               wdata_d   = C_M_AXI_DATA_WIDTH'(1);
            end
         end
         WR_START, WR_STOP: begin
            // AW and W complete independently; move on once both are gone
            if (M_AXI_AWREADY) awvalid_d = 1'b0;
            if (M_AXI_WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = (state_q == WR_START) ? WR_START_RESP : WR_STOP_RESP;
               bready_d = 1'b1;
            end
         end
         WR_START_RESP, WR_STOP_RESP: begin
            if (M_AXI_BVALID) begin
               bready_d = 1'b0;
               if (M_AXI_BRESP != RESP_OKAY) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  done_d  = 1'b1;
               end else if (state_q == WR_START_RESP) begin
                  state_d = WAIT;
                  cnt_d   = (period == '0) ? WAIT_W'(1) : period;
               end else begin
                  state_d   = RD_ADDR;
                  k_d       = 2'd1;
                  arvalid_d = 1'b1;
                  araddr_d  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - WAIT_W'(1);
            if (cnt_d == '0) begin
               state_d   = WR_STOP;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               wdata_d   = '0;
            end
         end
         RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID) begin
               rready_d = 1'b0;
               if (M_AXI_RRESP != RESP_OKAY) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  done_d  = 1'b1;
               end else if (k_q == 2'd3) begin
                  // last count goes straight to result so it lands with done
                  state_d  = DONE;
                  done_d   = 1'b1;
                  result_d = {M_AXI_RDATA[31:0], shadow_q};
               end else begin
                  if (k_q == 2'd1) shadow_d[31:0]  = M_AXI_RDATA[31:0];
                  else             shadow_d[63:32] = M_AXI_RDATA[31:0];
                  k_d       = k_q + 2'd1;
                  arvalid_d = 1'b1;
                  araddr_d  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({k_d, 2'b00});
                  state_d   = RD_ADDR;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         k_q       <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         rready_q  <= 1'b0;
         shadow_q  <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         rready_q  <= rready_d;
         shadow_q  <= shadow_d;
         result_q  <= result_d;
         done_q    <= done_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign result        = result_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_ros_poll_sequencer.sv
// Directed bench for ros_poll_sequencer with a small AXI4-Lite slave model of the sensor registers.
module tb_ros_poll_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        start = 1'b0;
   logic [15:0] period = '0;
   logic        busy, done, error;
   logic [95:0] result;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   ros_poll_sequencer dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .period(period),
      .busy(busy), .done(done), .error(error), .result(result),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   // slave configuration, written only by the stimulus process
   logic [31:0] regs [4];
   int          aw_delay_idx = -1;
   int          b_err_idx = -1;
   logic        r_err_en = 1'b0;
   logic [3:0]  r_err_addr = 4'h0;

   // slave state and logs
   int          wr_cnt, rd_cnt, aw_wait, aw_hi, w_hi, b_hs, unstable;
   logic        aw_got, w_got, prev_awv;
   logic [31:0] aw_addr_l, w_dat_l, prev_awaddr;
   logic [31:0] wr_addr_log [64];
   logic [31:0] wr_dat_log  [64];
   logic [31:0] rd_addr_log [64];

   assign M_AXI_AWREADY = M_AXI_AWVALID && ((wr_cnt != aw_delay_idx) || (aw_wait >= 3));
   assign M_AXI_WREADY  = M_AXI_WVALID;
   assign M_AXI_ARREADY = M_AXI_ARVALID && !M_AXI_RVALID;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
         M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
         M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
         prev_awv <= 1'b0; prev_awaddr <= '0;
      end else begin
         prev_awv    <= M_AXI_AWVALID && !M_AXI_AWREADY;
         prev_awaddr <= M_AXI_AWADDR;
         if (prev_awv && M_AXI_AWVALID && (M_AXI_AWADDR != prev_awaddr)) unstable <= unstable + 1;
         if (M_AXI_AWVALID) aw_hi <= aw_hi + 1;
         if (M_AXI_WVALID)  w_hi  <= w_hi + 1;
         if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait <= aw_wait + 1;
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got <= 1'b1; aw_addr_l <= M_AXI_AWADDR; aw_wait <= 0; end
         if (M_AXI_WVALID && M_AXI_WREADY)   begin w_got <= 1'b1;  w_dat_l <= M_AXI_WDATA; end
         if ((aw_got || (M_AXI_AWVALID && M_AXI_AWREADY)) && (w_got || (M_AXI_WVALID && M_AXI_WREADY))) begin
            wr_addr_log[wr_cnt[5:0]] <= (M_AXI_AWVALID && M_AXI_AWREADY) ? M_AXI_AWADDR : aw_addr_l;
            wr_dat_log[wr_cnt[5:0]]  <= (M_AXI_WVALID && M_AXI_WREADY) ? M_AXI_WDATA : w_dat_l;
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= (wr_cnt == b_err_idx) ? 2'b10 : 2'b00;
            wr_cnt <= wr_cnt + 1;
            aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (M_AXI_BVALID && M_AXI_BREADY) begin M_AXI_BVALID <= 1'b0; b_hs <= b_hs + 1; end
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RDATA  <= regs[M_AXI_ARADDR[3:2]];
            M_AXI_RRESP  <= (r_err_en && M_AXI_ARADDR[3:0] == r_err_addr) ? 2'b11 : 2'b00;
            rd_addr_log[rd_cnt[5:0]] <= M_AXI_ARADDR;
            rd_cnt <= rd_cnt + 1;
         end
         if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      end
   end

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // returns the done cycle counted from the start-sampling edge (first negedge after it = cycle 1)
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge ACLK);
         cyc++;
      end while (!done && cyc < 300);
   endtask

   task automatic do_run(input int p, output int cyc);
      @(negedge ACLK);
      period = 16'(p);
      start  = 1'b1;
      @(posedge ACLK);
      #1 start = 1'b0;
      wait_done(cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, w0, r0, a0, wv0, b0;
      logic [95:0] exp_res;
      wr_cnt = 0; rd_cnt = 0; aw_hi = 0; w_hi = 0; b_hs = 0; unstable = 0;
      regs[0] = 32'h0; regs[1] = 32'hA1; regs[2] = 32'hB2; regs[3] = 32'hC3;

      repeat (3) @(negedge ACLK);
      chk("rst_status", {busy, done, error}, 3'b000);
      chk("rst_result", result, 96'h0);
      chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
      chk("rst_addr_data", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, 96'h0);
      ARESET = 1'b0;
      repeat (2) @(negedge ACLK);

      // nominal run, P=5
      w0 = wr_cnt; r0 = rd_cnt;
      do_run(5, c);
      chk("nom_done_cycle", c, 16);
      exp_res = 96'h000000C3_000000B2_000000A1;
      chk("nom_result", result, exp_res);
      chk("nom_error", error, 0);
      chk("nom_wr_count", wr_cnt - w0, 2);
      chk("nom_wr0", {wr_addr_log[w0], wr_dat_log[w0]}, {32'h0, 32'h1});
      chk("nom_wr1", {wr_addr_log[w0+1], wr_dat_log[w0+1]}, {32'h0, 32'h0});
      chk("nom_rd_count", rd_cnt - r0, 3);
      chk("nom_rd_addrs", {rd_addr_log[r0], rd_addr_log[r0+1], rd_addr_log[r0+2]}, {32'h4, 32'h8, 32'hC});
      chk("nom_strb_prot", {M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, {4'hF, 6'h0});
      @(negedge ACLK);
      chk("nom_idle_after", {busy, done}, 2'b00);

      // AWREADY held off 3 cycles on the start write
      w0 = wr_cnt; a0 = aw_hi; wv0 = w_hi; b0 = b_hs;
      aw_delay_idx = wr_cnt;
      do_run(5, c);
      aw_delay_idx = -1;
      chk("bp_done_cycle", c, 19);
      chk("bp_aw_cycles", aw_hi - a0, 5);
      chk("bp_w_cycles", w_hi - wv0, 2);
      chk("bp_b_handshakes", b_hs - b0, 2);
      chk("bp_aw_stable", unstable, 0);
      chk("bp_result", result, exp_res);

      // SLVERR on the stop write
      r0 = rd_cnt;
      b_err_idx = wr_cnt + 1;
      do_run(5, c);
      b_err_idx = -1;
      chk("berr_done_cycle", c, 10);
      chk("berr_error", error, 1);
      chk("berr_no_reads", rd_cnt - r0, 0);
      chk("berr_result_kept", result, exp_res);
      repeat (3) @(negedge ACLK);
      chk("berr_error_held", {error, busy}, 2'b10);

      // clean run clears error and publishes new counts
      regs[1] = 32'h1111_0001; regs[2] = 32'h2222_0002; regs[3] = 32'h3333_0003;
      do_run(5, c);
      exp_res = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      chk("recover_error", error, 0);
      chk("recover_result", result, exp_res);

      // DECERR on the 0x8 read
      regs[1] = 32'h55; regs[2] = 32'h66; regs[3] = 32'h77;
      r0 = rd_cnt;
      r_err_en = 1'b1; r_err_addr = 4'h8;
      do_run(5, c);
      r_err_en = 1'b0;
      chk("rerr_done_cycle", c, 14);
      chk("rerr_error", error, 1);
      chk("rerr_rd_count", rd_cnt - r0, 2);
      chk("rerr_result_kept", result, exp_res);

      // P=0 behaves as P=1
      do_run(0, c);
      chk("p0_done_cycle", c, 12);
      chk("p0_result", result, {32'h77, 32'h66, 32'h55});
      chk("p0_error", error, 0);

      // start held high across a whole run
      w0 = wr_cnt;
      @(negedge ACLK);
      period = 16'd2;
      start  = 1'b1;
      @(posedge ACLK);
      wait_done(c);
      chk("hold_done_cycle", c, 13);
      chk("hold_one_run", wr_cnt - w0, 2);
      @(negedge ACLK);
      chk("hold_idle_gap", {busy, done}, 2'b00);
      @(negedge ACLK);
      chk("hold_second_busy", busy, 1);
      start = 1'b0;
      wait_done(c);
      chk("hold_second_done", c, 12);

      // reset asserted during WAIT
      @(negedge ACLK);
      period = 16'd20;
      start  = 1'b1;
      @(posedge ACLK);
      #1 start = 1'b0;
      repeat (6) @(negedge ACLK);
      #2 ARESET = 1'b1;
      #1;
      chk("mrst_status", {busy, done, error}, 3'b000);
      chk("mrst_result", result, 96'h0);
      chk("mrst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      regs[1] = 32'hA1; regs[2] = 32'hB2; regs[3] = 32'hC3;
      @(negedge ACLK);
      chk("mrst_idle", busy, 0);
      do_run(5, c);
      chk("mrst_done_cycle", c, 16);
      chk("mrst_result_after", result, 96'h000000C3_000000B2_000000A1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
